// File: rtl/sfx_sequencer.sv
// sfx_sequencer: turns Pong game events into a timed sequence of beat
// indices for the downstream tone lookup. Each input gets a rising-edge
// detector, and the events are arbitrated by priority. A running sequence
// can be pre-empted by an event of equal or higher priority. Every index is
// held for BEAT_DIV clock cycles.
module sfx_sequencer #(
    parameter int unsigned BEAT_DIV = 12_500_000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       paddle_hit,
    input  logic       border_hit,
    input  logic       win_evt,
    input  logic       mute,
    output logic [7:0] beat_num,
    output logic       busy,
    output logic       done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Sequence table: start index, end index, priority
    localparam logic [7:0] PADDLE_START = 8'd1;
    localparam logic [7:0] PADDLE_END   = 8'd5;
    localparam logic [1:0] PADDLE_PRIO  = 2'd1;
    localparam logic [7:0] BORDER_START = 8'd6;
    localparam logic [7:0] BORDER_END   = 8'd7;
    localparam logic [1:0] BORDER_PRIO  = 2'd0;
    localparam logic [7:0] WIN_START    = 8'd8;
    localparam logic [7:0] WIN_END      = 8'd13;
    localparam logic [1:0] WIN_PRIO     = 2'd2;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMER_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    logic [7:0]       cur_r;
    logic [7:0]       end_r;
    logic [1:0]       prio_r;
    logic [CNT_W-1:0] timer_r;
    logic             paddle_q_r;
    logic             border_q_r;
    logic             win_q_r;
    logic [7:0]       beat_num_r;
    logic             busy_r;
    logic             done_r;

    logic             paddle_ev_s;
    logic             border_ev_s;
    logic             win_ev_s;
    logic             ev_valid_s;
    logic [7:0]       ev_start_s;
    logic [7:0]       ev_end_s;
    logic [1:0]       ev_prio_s;
    logic             timer_last_s;

    state_t           state_nxt_s;
    logic [7:0]       cur_nxt_s;
    logic [7:0]       end_nxt_s;
    logic [1:0]       prio_nxt_s;
    logic [CNT_W-1:0] timer_nxt_s;
    logic             done_nxt_s;

    // The current input level against the previous sample gives a one-shot event
    assign paddle_ev_s  = paddle_hit & ~paddle_q_r;
    assign border_ev_s  = border_hit & ~border_q_r;
    assign win_ev_s     = win_evt    & ~win_q_r;
    assign timer_last_s = (timer_r == TIMER_LAST);

    // Arbitrate simultaneous events: the highest priority wins, the rest are dropped
    always_comb begin
        ev_valid_s = 1'b0;
        ev_start_s = 8'd0;
        ev_end_s   = 8'd0;
        ev_prio_s  = 2'd0;
        if (win_ev_s) begin
            ev_valid_s = 1'b1;
            ev_start_s = WIN_START;
            ev_end_s   = WIN_END;
            ev_prio_s  = WIN_PRIO;
        end else if (paddle_ev_s) begin
            ev_valid_s = 1'b1;
            ev_start_s = PADDLE_START;
            ev_end_s   = PADDLE_END;
            ev_prio_s  = PADDLE_PRIO;
        end else if (border_ev_s) begin
            ev_valid_s = 1'b1;
            ev_start_s = BORDER_START;
            ev_end_s   = BORDER_END;
            ev_prio_s  = BORDER_PRIO;
        end else begin
            ev_valid_s = 1'b0;
        end
    end

    // Next-state logic: start, restart, advance or finish the sequence
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        end_nxt_s   = end_r;
        prio_nxt_s  = prio_r;
        timer_nxt_s = timer_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ev_valid_s) begin
                    state_nxt_s = PLAY;
                    cur_nxt_s   = ev_start_s;
                    end_nxt_s   = ev_end_s;
                    prio_nxt_s  = ev_prio_s;
                    timer_nxt_s = TIMER_ZERO;
                end else begin
                    cur_nxt_s   = 8'd0;
                    timer_nxt_s = TIMER_ZERO;
                end
            end
            PLAY: begin
                if (ev_valid_s && (ev_prio_s >= prio_r)) begin
                    // A restart takes precedence over a natural completion
                    cur_nxt_s   = ev_start_s;
                    end_nxt_s   = ev_end_s;
                    prio_nxt_s  = ev_prio_s;
                    timer_nxt_s = TIMER_ZERO;
                end else if (timer_last_s) begin
                    if (cur_r != end_r) begin
                        cur_nxt_s   = cur_r + 8'd1;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        state_nxt_s = IDLE;
                        cur_nxt_s   = 8'd0;
                        prio_nxt_s  = 2'd0;
                        timer_nxt_s = TIMER_ZERO;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cur_nxt_s   = 8'd0;
                end_nxt_s   = 8'd0;
                prio_nxt_s  = 2'd0;
                timer_nxt_s = TIMER_ZERO;
            end
        endcase
    end

    // FSM state, edge-detect samples and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cur_r      <= 8'd0;
            end_r      <= 8'd0;
            prio_r     <= 2'd0;
            timer_r    <= TIMER_ZERO;
            paddle_q_r <= 1'b0;
            border_q_r <= 1'b0;
            win_q_r    <= 1'b0;
            beat_num_r <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_r      <= cur_nxt_s;
            end_r      <= end_nxt_s;
            prio_r     <= prio_nxt_s;
            timer_r    <= timer_nxt_s;
            paddle_q_r <= paddle_hit;
            border_q_r <= border_hit;
            win_q_r    <= win_evt;
            beat_num_r <= mute ? 8'd0 : cur_nxt_s;
            busy_r     <= (state_nxt_s == PLAY);
            done_r     <= done_nxt_s;
        end
    end

    assign beat_num = beat_num_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
